watchdog_kick_sched: RTL
========================

// Module: watchdog_kick_sched
// PURPOSE
//  Watchdog service scheduler for the Avalon interval-timer watchdog (3-bit address, 16-bit data, no waitrequest).
//  After reset it waits a fixed delay, then starts the watchdog once (control write with START and ITO).
//  It then collects one "alive" pulse from every enabled software/hardware client and, only once all are
//  present, kicks (reloads) the timer with a period write. A hung client withholds its pulse, kicks stop,
//  and the watchdog timeout drives resetrequest.
// PARAMETERS
//  NUM_CLIENTS  4   number of alive requesters (1..16)
//  START_DELAY  16  cycles in INIT after reset deassertion before the start write (>=1)
//  KICK_GAP     8   cycles in GAP after each kick before a new round may complete (>=1)
// PORTS
//  clk            in   1            system clock
//  reset          in   1            asynchronous, active-high reset
//  alive          in   NUM_CLIENTS  per-client one-cycle alive pulse (a level is treated as repeated pulses)
//  client_en      in   NUM_CLIENTS  per-client enable mask; disabled clients are not waited on
//  wd_chipselect  out  1            watchdog slave chipselect
//  wd_write_n     out  1            watchdog slave write strobe, active low
//  wd_address     out  3            watchdog slave register address
//  wd_writedata   out  16           watchdog slave write data
//  started        out  1            high from the start write onward
//  missing        out  NUM_CLIENTS  client_en & ~seen: clients not yet heard from in the current round
//  kick_count     out  16           number of kicks issued; wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset values: wd_chipselect=0, wd_write_n=1, wd_address=0, wd_writedata=0, started=0, kick_count=0,
//   seen=0, state=INIT, delay counter=0. missing is combinational and therefore equals client_en during reset.
//  All wd_* outputs are registered. A bus write is chipselect=1 and write_n=0 for exactly one cycle.
//   The slave accepts every write in that cycle. Outside a write, wd_chipselect=0, wd_write_n=1,
//   wd_address=0 and wd_writedata=0.
//  FSM states: INIT, START, COLLECT, KICK, GAP.
//   INIT: count START_DELAY cycles, then go to START.
//   START (1 cycle): write address 1, data 16'h0005 (ITO | START). started<=1. Next state COLLECT.
//   COLLECT: seen <= seen | alive. Define all_in = ((seen|alive) & client_en) == client_en && client_en != 0.
//    all_in is evaluated combinationally, so a pulse in cycle N counts in cycle N.
//    If all_in, go to KICK. In the same cycle, seen <= alive & ~client_en; enabled pulses are consumed by
//    this round.
//   KICK (1 cycle): write address 2, data 16'h0000 (period write; the timer force-reloads). kick_count+1.
//    Next state GAP.
//   GAP: KICK_GAP cycles, then COLLECT. seen keeps accumulating alive in KICK and GAP; those pulses
//    count toward the next round.
//  Latency: the final required alive pulse arrives in cycle N; the kick write is on the bus in cycle N+1.
//   The earliest next kick is in cycle N+2+KICK_GAP.
//  client_en == 0: no kick is ever issued, and the watchdog is allowed to expire (intended fail-safe).
//  client_en changes mid-round: the new mask is used immediately. Clearing the last missing client's bit
//   completes the round next cycle. Setting a new bit requires that client's pulse.
//  Alive pulses in INIT or START are ignored; seen is held at 0 until COLLECT.
//  Duplicate pulses from one client in a round have no extra effect.
//  kick_count wraps modulo 2^16.
//  Reset asserted mid-operation, including during a write cycle: all state and outputs return to reset values
//   immediately, any in-flight write is dropped, and the sequence restarts from INIT (start write reissued).
// TESTING
//  1 Reset, NUM_CLIENTS=4, START_DELAY=16: control write addr=1 data=0x0005 appears exactly once, in the
//    17th cycle after reset falls; started=1 from then on.
//  2 client_en=4'b1111; pulse clients 0,1,2,3 in separate cycles, last in cycle N: period write addr=2
//    data=0 in cycle N+1; kick_count=1; missing=4'b1111 afterwards.
//  3 All four clients pulse in the same cycle N: single kick at N+1. Pulses from all four during GAP:
//    second kick exactly at N+2+KICK_GAP.
//  4 client_en=4'b1011, client 3 never pulses: no kick; missing=4'b1000. Clear client_en[3]: kick on the
//    next cycle.
//  5 client_en=0 for 1000 cycles: no write after the start write; kick_count stays 0.
//  6 Assert reset during a KICK cycle: wd_chipselect=0 and wd_write_n=1 immediately. After release, the
//    start write is reissued after START_DELAY and kick_count restarts at 0. Preload 0xFFFF kicks and kick
//    once more: kick_count reads 0x0000.

Source files
------------

// File: rtl/watchdog_kick_sched.sv
// Watchdog service scheduler: starts the interval-timer watchdog once after a power-up delay,
// then reloads it only when every enabled client has reported alive in the current round.
module watchdog_kick_sched #(
    parameter int NUM_CLIENTS = 4,
    parameter int START_DELAY = 16,
    parameter int KICK_GAP    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CLIENTS-1:0] alive,
    input  logic [NUM_CLIENTS-1:0] client_en,
    output logic                   wd_chipselect,
    output logic                   wd_write_n,
    output logic [2:0]             wd_address,
    output logic [15:0]            wd_writedata,
    output logic                   started,
    output logic [NUM_CLIENTS-1:0] missing,
    output logic [15:0]            kick_count
);

    localparam int CNT_MAX = (START_DELAY > KICK_GAP) ? START_DELAY : KICK_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0]  ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  ADDR_PERIOD  = 3'd2;
    localparam logic [15:0] CTRL_START   = 16'h0005;  // ITO | START

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_START   = 3'd1,
        S_COLLECT = 3'd2,
        S_KICK    = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CLIENTS-1:0] seen_q, seen_d;
    logic                   started_q, started_d;
    logic [15:0]            kick_count_q, kick_count_d;
    logic                   cs_q, cs_d;
    logic                   wr_n_q, wr_n_d;
    logic [2:0]             addr_q, addr_d;
    logic [15:0]            data_q, data_d;
    logic                   all_in;

    // A pulse arriving this cycle already counts toward completing the round.
    assign all_in = (((seen_q | alive) & client_en) == client_en) && (client_en != '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seen_d       = seen_q;
        started_d    = started_q;
        kick_count_d = kick_count_q;
        cs_d         = 1'b0;
        wr_n_d       = 1'b1;
        addr_d       = 3'd0;
        data_d       = 16'h0000;

        unique case (state_q)
            S_INIT: begin
                seen_d = '0;
                if (cnt_q == CNT_W'(START_DELAY - 1)) begin
                    cnt_d     = '0;
                    state_d   = S_START;
                    started_d = 1'b1;
                    cs_d      = 1'b1;
                    wr_n_d    = 1'b0;
                    addr_d    = ADDR_CONTROL;
                    data_d    = CTRL_START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_START: begin
                seen_d  = '0;
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                seen_d = seen_q | alive;
            end
            S_KICK: begin
                seen_d  = seen_q | alive;
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                seen_d = seen_q | alive;
                if (cnt_q == CNT_W'(KICK_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_COLLECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
                seen_d  = '0;
            end
        endcase

        // The last GAP cycle may already complete the next round, so the gap is exactly KICK_GAP.
        if ((state_q == S_COLLECT || (state_q == S_GAP && cnt_q == CNT_W'(KICK_GAP - 1))) && all_in) begin
            state_d      = S_KICK;
            cnt_d        = '0;
            seen_d       = alive & ~client_en;
            kick_count_d = kick_count_q + 16'd1;
            cs_d         = 1'b1;
            wr_n_d       = 1'b0;
            addr_d       = ADDR_PERIOD;
            data_d       = 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            seen_q       <= '0;
            started_q    <= 1'b0;
            kick_count_q <= 16'h0000;
            cs_q         <= 1'b0;
            wr_n_q       <= 1'b1;
            addr_q       <= 3'd0;
            data_q       <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            started_q    <= started_d;
            kick_count_q <= kick_count_d;
            cs_q         <= cs_d;
            wr_n_q       <= wr_n_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign wd_chipselect = cs_q;
    assign wd_write_n    = wr_n_q;
    assign wd_address    = addr_q;
    assign wd_writedata  = data_q;
    assign started       = started_q;
    assign kick_count    = kick_count_q;
    assign missing       = client_en & ~seen_q;

endmodule
